// File: rtl/pcd8544_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : pcd8544_rx_if
// Description : Bus bundle for the PCD8544-style receiver. Carries the serial
//               link from the host (sclk, mosi, cs, dc, lcd_rst) and the
//               receiver's write/command strobes back to the host side.
//   master : drives the serial link, observes fb_we/fb_addr/fb_data,
//            cmd_valid/cmd_byte and err.
//   slave  : the receiver; the mirror image of master.
// Revision    : 1.0 - initial release
// ============================================================================
interface pcd8544_rx_if;
    logic       sclk;
    logic       mosi;
    logic       cs;
    logic       dc;
    logic       lcd_rst;
    logic       fb_we;
    logic [8:0] fb_addr;
    logic [7:0] fb_data;
    logic       cmd_valid;
    logic [7:0] cmd_byte;
    logic       err;

    modport master (
        output sclk, mosi, cs, dc, lcd_rst,
        input  fb_we, fb_addr, fb_data, cmd_valid, cmd_byte, err
    );

    modport slave (
        input  sclk, mosi, cs, dc, lcd_rst,
        output fb_we, fb_addr, fb_data, cmd_valid, cmd_byte, err
    );
endinterface
`default_nettype wire

// File: rtl/pcd8544_rx.sv
`default_nettype none
// ============================================================================
// Module      : pcd8544_rx
// Description : Receiver for a PCD8544-style LCD controller serial port.
//               Oversamples the SPI mode-0 link with clk, assembles bytes
//               MSB first, and either writes display data to a framebuffer
//               (with auto-advancing X/Y pointers) or decodes command bytes
//               into the controller's configuration registers.
// Ports       : clk        system clock
//               reset      synchronous active-low reset
//               bus        pcd8544_rx_if.slave (serial in, strobes out)
//               x_addr/y_addr            current write pointers
//               h_mode/v_mode/power_down function-set bits H, V, PD
//               disp_mode                {D,E} display control
//               vop/bias/tc              extended-set registers
// Revision    : 1.0 - initial release
// ============================================================================
module pcd8544_rx #(
    parameter int COLS = 84,
    parameter int ROWS = 6
) (
    input  wire logic       clk,
    input  wire logic       reset,
    pcd8544_rx_if.slave     bus,
    output logic [6:0]      x_addr,
    output logic [2:0]      y_addr,
    output logic            h_mode,
    output logic            v_mode,
    output logic            power_down,
    output logic [1:0]      disp_mode,
    output logic [6:0]      vop,
    output logic [2:0]      bias,
    output logic [1:0]      tc
);

    localparam logic [6:0] c_x_max = 7'(COLS - 1);
    localparam logic [2:0] c_y_max = 3'(ROWS - 1);
    localparam logic [8:0] c_cols9 = 9'(COLS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_DECODE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers. cs and lcd_rst come out of reset in their
    // inactive (high) state so the receiver does not see a false select.
    // ------------------------------------------------------------------
    logic [1:0] r_sclk_sync;
    logic [1:0] r_mosi_sync;
    logic [1:0] r_cs_sync;
    logic [1:0] r_dc_sync;
    logic [1:0] r_lrst_sync;
    logic       r_sclk_prev;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sclk_sync <= 2'b00;
            r_mosi_sync <= 2'b00;
            r_cs_sync   <= 2'b11;
            r_dc_sync   <= 2'b00;
            r_lrst_sync <= 2'b11;
            r_sclk_prev <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[0], bus.sclk};
            r_mosi_sync <= {r_mosi_sync[0], bus.mosi};
            r_cs_sync   <= {r_cs_sync[0],   bus.cs};
            r_dc_sync   <= {r_dc_sync[0],   bus.dc};
            r_lrst_sync <= {r_lrst_sync[0], bus.lcd_rst};
            r_sclk_prev <= r_sclk_sync[1];
        end
    end

    logic w_sclk_rise;
    logic w_cs_s;
    logic w_clear;

    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_prev;
    assign w_cs_s      = r_cs_sync[1];
    // Either reset source returns the whole receiver to its power-on state.
    assign w_clear     = ~reset | ~r_lrst_sync[1];

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    state_t     r_state;
    state_t     w_state_next;
    logic [2:0] r_bit_cnt;
    logic       w_shift_en;
    logic       w_last_bit;

    assign w_shift_en = (r_state == ST_SHIFT) && !w_cs_s && w_sclk_rise;
    assign w_last_bit = w_shift_en && (r_bit_cnt == 3'd7);

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_cs_s) begin
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_cs_s) begin
                    w_state_next = ST_IDLE;
                end else if (w_last_bit) begin
                    w_state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                w_state_next = w_cs_s ? ST_IDLE : ST_SHIFT;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    // Only the first seven bits ever need holding; the eighth is taken
    // straight from the synchronizer when the byte completes.
    logic [6:0] r_shreg;
    logic [7:0] w_byte;
    logic       r_fb_we;
    logic [8:0] r_fb_addr;
    logic [7:0] r_fb_data;
    logic       r_cmd_valid;
    logic [7:0] r_cmd_byte;
    logic       r_err;
    logic [6:0] r_x;
    logic [2:0] r_y;
    logic       r_h;
    logic       r_v;
    logic       r_pd;
    logic [1:0] r_disp_mode;
    logic [6:0] r_vop;
    logic [2:0] r_bias;
    logic [1:0] r_tc;

    assign w_byte = {r_shreg, r_mosi_sync[1]};

    // Pointer advance after a data write; the wrap order depends on V.
    logic [6:0] w_x_adv;
    logic [2:0] w_y_adv;
    logic [8:0] w_lin_addr;

    always_comb begin
        w_x_adv = r_x;
        w_y_adv = r_y;
        if (!r_v) begin
            if (r_x == c_x_max) begin
                w_x_adv = 7'd0;
                w_y_adv = (r_y == c_y_max) ? 3'd0 : r_y + 3'd1;
            end else begin
                w_x_adv = r_x + 7'd1;
            end
        end else begin
            if (r_y == c_y_max) begin
                w_y_adv = 3'd0;
                w_x_adv = (r_x == c_x_max) ? 7'd0 : r_x + 7'd1;
            end else begin
                w_y_adv = r_y + 3'd1;
            end
        end
    end

    assign w_lin_addr = {6'd0, r_y} * c_cols9 + {2'd0, r_x};

    // The byte is decoded on the edge that ends the 8th-rise cycle, so the
    // strobes and the updated registers are visible during DECODE.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_bit_cnt   <= 3'd0;
            r_shreg     <= 7'd0;
            r_fb_we     <= 1'b0;
            r_fb_addr   <= 9'd0;
            r_fb_data   <= 8'd0;
            r_cmd_valid <= 1'b0;
            r_cmd_byte  <= 8'd0;
            r_err       <= 1'b0;
            r_x         <= 7'd0;
            r_y         <= 3'd0;
            r_h         <= 1'b0;
            r_v         <= 1'b0;
            r_pd        <= 1'b1;
            r_disp_mode <= 2'b00;
            r_vop       <= 7'd0;
            r_bias      <= 3'd0;
            r_tc        <= 2'd0;
        end else begin
            r_fb_we     <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_err       <= 1'b0;

            if (r_state == ST_SHIFT && w_cs_s) begin
                r_bit_cnt <= 3'd0;
            end else if (w_shift_en) begin
                r_shreg   <= w_byte[6:0];
                r_bit_cnt <= r_bit_cnt + 3'd1;   // wraps 7 -> 0 on the last bit
            end

            if (w_last_bit) begin
                if (r_dc_sync[1]) begin
                    r_fb_we   <= 1'b1;
                    r_fb_data <= w_byte;
                    r_fb_addr <= w_lin_addr;
                    r_x       <= w_x_adv;
                    r_y       <= w_y_adv;
                end else begin
                    r_cmd_byte  <= w_byte;
                    r_cmd_valid <= 1'b1;
                    if (w_byte == 8'h00) begin
                        // NOP
                    end else if (w_byte[7:3] == 5'b00100) begin
                        // Function set is reachable from either instruction set.
                        r_pd <= w_byte[2];
                        r_v  <= w_byte[1];
                        r_h  <= w_byte[0];
                    end else if (!r_h) begin
                        if (w_byte[7:3] == 5'b00001) begin
                            r_disp_mode <= {w_byte[2], w_byte[0]};
                        end else if (w_byte[7:3] == 5'b01000) begin
                            if (w_byte[2:0] <= c_y_max) begin
                                r_y <= w_byte[2:0];
                            end else begin
                                r_err <= 1'b1;
                            end
                        end else if (w_byte[7]) begin
                            if (w_byte[6:0] <= c_x_max) begin
                                r_x <= w_byte[6:0];
                            end else begin
                                r_err <= 1'b1;
                            end
                        end else begin
                            r_err <= 1'b1;
                        end
                    end else begin
                        if (w_byte[7:2] == 6'b000001) begin
                            r_tc <= w_byte[1:0];
                        end else if (w_byte[7:3] == 5'b00010) begin
                            r_bias <= w_byte[2:0];
                        end else if (w_byte[7]) begin
                            r_vop <= w_byte[6:0];
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign bus.fb_we     = r_fb_we;
    assign bus.fb_addr   = r_fb_addr;
    assign bus.fb_data   = r_fb_data;
    assign bus.cmd_valid = r_cmd_valid;
    assign bus.cmd_byte  = r_cmd_byte;
    assign bus.err       = r_err;

    assign x_addr     = r_x;
    assign y_addr     = r_y;
    assign h_mode     = r_h;
    assign v_mode     = r_v;
    assign power_down = r_pd;
    assign disp_mode  = r_disp_mode;
    assign vop        = r_vop;
    assign bias       = r_bias;
    assign tc         = r_tc;

endmodule
`default_nettype wire
